bus_register_slave: RTL and testbench

BUS_REGISTER_SLAVE -- requirements
Module: bus_register_slave

---
 rtl/bus_register_slave_pkg.sv | 38 +++
 rtl/bus_register_slave.sv | 159 +++++++++++++++
 tb/tb_bus_register_slave.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_register_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_register_slave_pkg
// Purpose  : Shared handshake state encoding and status-word layout.
// Revision : 1.0
// ============================================================================
package bus_register_slave_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W_ACK   = 3'd1,
        S_W_REL   = 3'd2,
        S_R0_WAIT = 3'd3,
        S_R0_ACK  = 3'd4,
        S_R1_WAIT = 3'd5,
        S_R1_ACK  = 3'd6,
        S_DONE    = 3'd7
    } bus_state_t;

    localparam int c_status_in_lsb = 16;
    localparam int c_ro_err_bit    = 15;
    localparam int c_count_width   = 8;

    function automatic logic [31:0] make_status_word(
        input logic [15:0]              status,
        input logic                     ro_err,
        input logic [c_count_width-1:0] count
    );
        logic [31:0] w_word;
        w_word                          = '0;
        w_word[31:c_status_in_lsb]      = status;
        w_word[c_ro_err_bit]            = ro_err;
        w_word[c_count_width-1:0]       = count;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_register_slave.sv
`default_nettype none
// ============================================================================
// Module   : bus_register_slave
// Purpose  : Handshaked register-block slave: one write word, then register
//            word and status word read back; last register is read-only status.
// Revision : 1.0
// ============================================================================
module bus_register_slave
    import bus_register_slave_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h10,
    parameter int         NUM_REGS  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  register_address,
    input  logic                        register_address_valid,
    input  logic                        bus_handshake_1,
    output logic                        bus_handshake_2,
    input  logic [31:0]                 data_in,
    output logic [31:0]                 data_out,
    output logic [32*(NUM_REGS-1)-1:0]  reg_out,
    input  logic [15:0]                 status_in
);

    localparam int         c_num_wr     = NUM_REGS - 1;
    localparam logic [3:0] c_status_idx = 4'(NUM_REGS - 1);
    localparam logic [8:0] c_limit      = {1'b0, BASE_ADDR} + 9'(NUM_REGS);

    bus_state_t                 r_state;
    logic [3:0]                 r_index;
    logic                       r_hs2;
    logic [31:0]                r_data_out;
    logic [c_count_width-1:0]   r_txn_count;
    logic                       r_ro_write_err;
    logic [31:0]                r_regs [c_num_wr];

    logic                       w_selected;
    logic [3:0]                 w_index;
    logic [31:0]                w_status;
    logic [31:0]                w_rd_word;

    always_comb begin
        w_selected = register_address_valid
                  && ({1'b0, register_address} >= {1'b0, BASE_ADDR})
                  && ({1'b0, register_address} <  c_limit);
        w_index    = 4'(register_address - BASE_ADDR);
        w_status   = make_status_word(status_in, r_ro_write_err, r_txn_count);
    end

    // Read mux over the latched index; the status slot has no storage.
    always_comb begin
        w_rd_word = w_status;
        for (int i = 0; i < c_num_wr; i++) begin
            if (r_index == 4'(i)) begin
                w_rd_word = r_regs[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_index        <= '0;
            r_hs2          <= 1'b0;
            r_data_out     <= '0;
            r_txn_count    <= '0;
            r_ro_write_err <= 1'b0;
            for (int i = 0; i < c_num_wr; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_hs2      <= 1'b0;
            r_data_out <= '0;
            // Master abandoning the sequence always wins over the handshake.
            if (r_state != S_IDLE && !register_address_valid) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_selected && bus_handshake_1) begin
                            r_state <= S_W_ACK;
                            r_hs2   <= 1'b1;
                            r_index <= w_index;
                            if (w_index == c_status_idx) begin
                                r_ro_write_err <= 1'b1;
                            end else begin
                                for (int i = 0; i < c_num_wr; i++) begin
                                    if (w_index == 4'(i)) begin
                                        r_regs[i] <= data_in;
                                    end
                                end
                            end
                        end
                    end
                    S_W_ACK: begin
                        if (!bus_handshake_1) begin
                            r_state <= S_W_REL;
                        end else begin
                            r_hs2 <= 1'b1;
                        end
                    end
                    S_W_REL: begin
                        r_state    <= S_R0_WAIT;
                        r_data_out <= w_rd_word;
                    end
                    S_R0_WAIT: begin
                        r_data_out <= w_rd_word;
                        if (bus_handshake_1) begin
                            r_state <= S_R0_ACK;
                            r_hs2   <= 1'b1;
                        end
                    end
                    S_R0_ACK: begin
                        if (!bus_handshake_1) begin
                            r_state    <= S_R1_WAIT;
                            r_data_out <= w_status;
                        end else begin
                            r_hs2      <= 1'b1;
                            r_data_out <= r_data_out;
                        end
                    end
                    S_R1_WAIT: begin
                        r_data_out <= w_status;
                        if (bus_handshake_1) begin
                            r_state <= S_R1_ACK;
                            r_hs2   <= 1'b1;
                        end
                    end
                    S_R1_ACK: begin
                        if (!bus_handshake_1) begin
                            r_state        <= S_DONE;
                            r_txn_count    <= r_txn_count + 1'b1;
                            r_ro_write_err <= 1'b0;
                        end else begin
                            r_hs2      <= 1'b1;
                            r_data_out <= r_data_out;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < c_num_wr; g++) begin : g_reg_out
        assign reg_out[32*g +: 32] = r_regs[g];
    end

    assign bus_handshake_2 = r_hs2;
    assign data_out        = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_bus_register_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_register_slave
// Purpose  : Self-checking bench: vector table of full transactions with a
//            read-data scoreboard, plus abort, unselected, wrap and reset cases.
// Revision : 1.0
// ============================================================================
module tb_bus_register_slave;

    localparam logic [7:0] c_base = 8'h10;
    localparam int         c_regs = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  register_address = '0;
    logic        register_address_valid = 1'b0;
    logic        bus_handshake_1 = 1'b0;
    logic        bus_handshake_2;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic [95:0] reg_out;
    logic [15:0] status_in = '0;

    always #5 clk = ~clk;

    bus_register_slave #(.BASE_ADDR(c_base), .NUM_REGS(c_regs)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .register_address       (register_address),
        .register_address_valid (register_address_valid),
        .bus_handshake_1        (bus_handshake_1),
        .bus_handshake_2        (bus_handshake_2),
        .data_in                (data_in),
        .data_out               (data_out),
        .reg_out                (reg_out),
        .status_in              (status_in)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  alt;
        logic [31:0] wdata;
        logic [15:0] st;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [95:0] exp_reg;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] q_exp [$];
    int          total = 0;
    int          bad = 0;
    int          txn_no = 0;

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (txn %0d): got %h expected %h", name, txn_no, got, exp);
        end
    endtask

    task automatic wait_hs2(input logic val, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus_handshake_2 === val) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s (txn %0d): hs2 is %b, waited for %b", name, txn_no, bus_handshake_2, val);
        end
    endtask

    task automatic pop_check(input string name);
        logic [31:0] e;
        if (q_exp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s (txn %0d): got %h with no expected word queued", name, txn_no, data_out);
        end else begin
            e = q_exp.pop_front();
            chk(name, {64'h0, data_out}, {64'h0, e});
        end
    endtask

    // One complete write + two-read sequence; alt is driven onto the address
    // bus after the write ack to show the latched index is kept.
    task automatic do_txn(input logic [7:0] addr, input logic [7:0] alt, input logic [31:0] wdata,
                          input logic [31:0] e0, input logic [31:0] e1);
        q_exp.push_back(e0);
        q_exp.push_back(e1);
        @(negedge clk);
        register_address       = addr;
        register_address_valid = 1'b1;
        data_in                = wdata;
        bus_handshake_1        = 1'b1;
        wait_hs2(1'b1, "w_ack");
        bus_handshake_1  = 1'b0;
        register_address = alt;
        wait_hs2(1'b0, "w_rel");
        bus_handshake_1 = 1'b1;
        wait_hs2(1'b1, "r0_ack");
        pop_check("word0");
        bus_handshake_1 = 1'b0;
        wait_hs2(1'b0, "r0_rel");
        bus_handshake_1 = 1'b1;
        wait_hs2(1'b1, "r1_ack");
        pop_check("word1");
        bus_handshake_1 = 1'b0;
        wait_hs2(1'b0, "r1_rel");
        register_address_valid = 1'b0;
        @(negedge clk);
        txn_no++;
    endtask

    initial begin
        logic        any_hs2;
        logic [31:0] or_dout;
        logic [7:0]  unsel [3];

        vecs[0] = '{8'h11, 8'h11, 32'hDEADBEEF, 16'h1234, 32'hDEADBEEF, 32'h1234_0000, {32'h0, 32'hDEADBEEF, 32'h0}};
        vecs[1] = '{8'h10, 8'h10, 32'h000000A5, 16'hABCD, 32'h000000A5, 32'hABCD_0001, {32'h0, 32'hDEADBEEF, 32'hA5}};
        vecs[2] = '{8'h13, 8'h13, 32'hFFFFFFFF, 16'h0F0F, 32'h0F0F_8002, 32'h0F0F_8002, {32'h0, 32'hDEADBEEF, 32'hA5}};
        vecs[3] = '{8'h12, 8'h12, 32'h12345678, 16'h0000, 32'h12345678, 32'h0000_0003, {32'h12345678, 32'hDEADBEEF, 32'hA5}};
        vecs[4] = '{8'h11, 8'h13, 32'hCAFEF00D, 16'h5555, 32'hCAFEF00D, 32'h5555_0004, {32'h12345678, 32'hCAFEF00D, 32'hA5}};
        vecs[5] = '{8'h13, 8'h10, 32'h00000000, 16'h0001, 32'h0001_8005, 32'h0001_8005, {32'h12345678, 32'hCAFEF00D, 32'hA5}};
        vecs[6] = '{8'h10, 8'h10, 32'h00000000, 16'h8000, 32'h00000000, 32'h8000_0006, {32'h12345678, 32'hCAFEF00D, 32'h0}};
        unsel[0] = 8'h20;
        unsel[1] = 8'h0F;
        unsel[2] = 8'h14;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset hs2", {95'h0, bus_handshake_2}, 96'h0);
        chk("reset data_out", {64'h0, data_out}, 96'h0);
        chk("reset reg_out", reg_out, 96'h0);
        reset = 1'b1;

        // Vector table
        for (int v = 0; v < 7; v++) begin
            status_in = vecs[v].st;
            do_txn(vecs[v].addr, vecs[v].alt, vecs[v].wdata, vecs[v].exp0, vecs[v].exp1);
            chk("reg_out after txn", reg_out, vecs[v].exp_reg);
        end
        status_in = 16'h0;

        // Unselected addresses, including both range edges
        for (int a = 0; a < 3; a++) begin
            any_hs2 = 1'b0;
            or_dout = '0;
            @(negedge clk);
            register_address       = unsel[a];
            register_address_valid = 1'b1;
            data_in                = 32'hFFFFFFFF;
            for (int i = 0; i < 8; i++) begin
                bus_handshake_1 = ~bus_handshake_1;
                @(negedge clk);
                any_hs2 = any_hs2 | bus_handshake_2;
                or_dout = or_dout | data_out;
            end
            bus_handshake_1        = 1'b0;
            register_address_valid = 1'b0;
            chk("unselected hs2", {95'h0, any_hs2}, 96'h0);
            chk("unselected data_out", {64'h0, or_dout}, 96'h0);
        end
        chk("unselected reg_out", reg_out, {32'h12345678, 32'hCAFEF00D, 32'h0});

        // Drop valid while in S_R0_ACK
        @(negedge clk);
        register_address       = 8'h12;
        register_address_valid = 1'b1;
        data_in                = 32'h0BAD0BAD;
        bus_handshake_1        = 1'b1;
        wait_hs2(1'b1, "abort w_ack");
        bus_handshake_1 = 1'b0;
        wait_hs2(1'b0, "abort w_rel");
        bus_handshake_1 = 1'b1;
        wait_hs2(1'b1, "abort r0_ack");
        register_address_valid = 1'b0;
        @(negedge clk);
        chk("abort hs2", {95'h0, bus_handshake_2}, 96'h0);
        chk("abort data_out", {64'h0, data_out}, 96'h0);
        bus_handshake_1 = 1'b0;
        @(negedge clk);
        chk("abort reg_out", reg_out, {32'h0BAD0BAD, 32'hCAFEF00D, 32'h0});
        txn_no++;
        do_txn(8'h10, 8'h10, 32'h00000001, 32'h00000001, 32'h0000_0007);

        // Counter wrap: 8 done so far, 248 more make 256
        for (int k = 0; k < 248; k++) begin
            do_txn(8'h10, 8'h10, 32'(k), 32'(k), {16'h0, 1'b0, 7'h0, 8'(8 + k)});
        end
        do_txn(8'h10, 8'h10, 32'h0000000A, 32'h0000000A, 32'h0000_0000);

        // Asynchronous reset while in S_W_ACK
        @(negedge clk);
        register_address       = 8'h11;
        register_address_valid = 1'b1;
        data_in                = 32'h00000077;
        bus_handshake_1        = 1'b1;
        wait_hs2(1'b1, "rst w_ack");
        #1 reset = 1'b0;
        #1;
        chk("midreset hs2", {95'h0, bus_handshake_2}, 96'h0);
        chk("midreset data_out", {64'h0, data_out}, 96'h0);
        chk("midreset reg_out", reg_out, 96'h0);
        @(negedge clk);
        bus_handshake_1        = 1'b0;
        register_address_valid = 1'b0;
        reset                  = 1'b1;
        do_txn(8'h11, 8'h11, 32'h55AA55AA, 32'h55AA55AA, 32'h0000_0000);
        chk("post-reset reg_out", reg_out, {32'h0, 32'h55AA55AA, 32'h0});
        chk("scoreboard drained", 96'(q_exp.size()), 96'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
